// File: rtl/switch_debouncer_pkg.sv
// Shared types and constants for the switch debouncer.
package switch_debouncer_pkg;

   // Per-channel debounce state.
   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } ch_state_e;

   localparam int DEFAULT_MAX_COUNT   = 10_000_000;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Width of the per-channel persistence counter; never narrower than one bit.
   function automatic int cnt_width(input int max_count);
      return (max_count > 2) ? $clog2(max_count) : 1;
   endfunction

endpackage : switch_debouncer_pkg

// File: rtl/switch_debouncer_debounce_channel.sv
// One debounced switch bit: input synchroniser, STABLE/PENDING FSM and
// persistence counter. 'accept' is high in the cycle before 'stable' takes
// the new level, so the parent can register strobes that line up with it.
module debounce_channel
   import switch_debouncer_pkg::*;
#(
   parameter int MAX_COUNT   = DEFAULT_MAX_COUNT,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_in,
   output logic stable,
   output logic accept
);

   localparam int CW = cnt_width(MAX_COUNT);
   // The cycle that detects the mismatch already counts as the first cycle
   // of persistence, so the count tops out one below MAX_COUNT-1.
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 2);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sync_lvl;
   ch_state_e              state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_q, stable_d;

   // Shift the raw level through the synchroniser chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sw_in};
   end

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   // Next-state logic: accept a new level only after it persists MAX_COUNT cycles.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      accept   = 1'b0;
      case (state_q)
         ST_STABLE: begin
            if (sync_lvl != stable_q) begin
               state_d = ST_PENDING;
               cnt_d   = '0;
            end
         end
         ST_PENDING: begin
            if (sync_lvl == stable_q) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               stable_d = sync_lvl;
               state_d  = ST_STABLE;
               cnt_d    = '0;
               accept   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         sync_q   <= '0;
         state_q  <= ST_STABLE;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable = stable_q;

endmodule : debounce_channel

// File: rtl/switch_debouncer.sv
// N_CH-wide switch debouncer feeding the majority detector.
// Optional per-channel edge strobes: define SWITCH_DEBOUNCER_EDGE_PULSE_EN.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int N_CH        = 3,
   parameter int MAX_COUNT   = DEFAULT_MAX_COUNT,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] sw_in,
   output logic [N_CH-1:0] sw_stable,
   output logic            sw_changed,
   output logic            ready,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse
);

   localparam int SETTLE = SYNC_STAGES + MAX_COUNT;
   localparam int TW     = $clog2(SETTLE + 1);

   logic [N_CH-1:0] stable_vec;
   logic [N_CH-1:0] accept_vec;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .MAX_COUNT   (MAX_COUNT),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .sw_in  (sw_in[i]),
         .stable (stable_vec[i]),
         .accept (accept_vec[i])
      );
   end

   assign sw_stable = stable_vec;

   logic          sw_changed_q, sw_changed_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          ready_q, ready_d;

   // Change strobe and startup settle timer.
   always_comb begin
      sw_changed_d = |accept_vec;
      tmr_d        = tmr_q;
      ready_d      = ready_q;
      if (!ready_q) begin
         tmr_d = tmr_q + 1'b1;
         if (tmr_q == TW'(SETTLE - 1)) begin
            ready_d = 1'b1;
         end
      end
   end

   // Registers for the change strobe and settle timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_changed_q <= 1'b0;
         tmr_q        <= '0;
         ready_q      <= 1'b0;
      end else begin
         sw_changed_q <= sw_changed_d;
         tmr_q        <= tmr_d;
         ready_q      <= ready_d;
      end
   end

   assign sw_changed = sw_changed_q;
   assign ready      = ready_q;

`ifdef SWITCH_DEBOUNCER_EDGE_PULSE_EN
   logic [N_CH-1:0] rise_q, rise_d;
   logic [N_CH-1:0] fall_q, fall_d;

   // An accepting channel flips its level, so the current level gives the direction.
   always_comb begin
      rise_d = accept_vec & ~stable_vec;
      fall_d = accept_vec & stable_vec;
   end

   // Edge strobe registers, aligned with sw_changed.
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
`else
   assign rise_pulse = '0;
   assign fall_pulse = '0;
`endif

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (MAX_COUNT=4, SYNC_STAGES=2).
module tb_switch_debouncer;

   localparam int NC = 3;
   localparam int MC = 4;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NC-1:0] sw_in = '0;
   logic [NC-1:0] sw_stable, rise_pulse, fall_pulse;
   logic          sw_changed, ready;

   int checks   = 0;
   int failures = 0;

   switch_debouncer #(
      .N_CH        (NC),
      .MAX_COUNT   (MC),
      .SYNC_STAGES (SS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sw_in      (sw_in),
      .sw_stable  (sw_stable),
      .sw_changed (sw_changed),
      .ready      (ready),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a level is accepted once the synchronised view of it
   // has disagreed with the stable level for MC consecutive edges.
   logic [NC-1:0] m_dl [SS];
   logic [NC-1:0] m_stable;
   int            m_run [NC];
   int            m_edges;
   logic          e_changed, e_ready;
   logic [NC-1:0] e_rise, e_fall;

   task automatic model_edge(input logic r, input logic [NC-1:0] s);
      logic [NC-1:0] view, nxt;
      if (r) begin
         for (int k = 0; k < SS; k++) m_dl[k] = '0;
         for (int i = 0; i < NC; i++) m_run[i] = 0;
         m_stable = '0; m_edges = 0;
         e_changed = 1'b0; e_ready = 1'b0; e_rise = '0; e_fall = '0;
      end else begin
         view = m_dl[SS-1];
         for (int k = SS-1; k > 0; k--) m_dl[k] = m_dl[k-1];
         m_dl[0] = s;
         nxt = m_stable;
         for (int i = 0; i < NC; i++) begin
            if (view[i] != m_stable[i]) begin
               m_run[i]++;
               if (m_run[i] == MC) begin
                  nxt[i]   = view[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         e_changed = (nxt != m_stable);
`ifdef SWITCH_DEBOUNCER_EDGE_PULSE_EN
         e_rise = nxt & ~m_stable;
         e_fall = ~nxt & m_stable;
`else
         e_rise = '0;
         e_fall = '0;
`endif
         m_stable = nxt;
         if (m_edges < SS + MC) m_edges++;
         e_ready = (m_edges >= SS + MC);
      end
   endtask

   // One clock: drive on the falling edge, update the model at the rising edge,
   // compare shortly after it.
   task automatic step(input logic r, input logic [NC-1:0] s);
      @(negedge clk);
      rst   = r;
      sw_in = s;
      @(posedge clk);
      model_edge(r, s);
      #1;
      check("model_stable",  32'(sw_stable),  32'(m_stable));
      check("model_changed", 32'(sw_changed), 32'(e_changed));
      check("model_ready",   32'(ready),      32'(e_ready));
      check("model_rise",    32'(rise_pulse), 32'(e_rise));
      check("model_fall",    32'(fall_pulse), 32'(e_fall));
   endtask

   typedef struct {
      logic          r;
      logic [NC-1:0] s;
      int            n;
      logic [NC-1:0] x_stable;
      logic          x_changed;
      logic          x_ready;
      logic [NC-1:0] x_rise;
      logic [NC-1:0] x_fall;
   } vec_t;

   vec_t vecs [14];

   initial begin
      logic [NC-1:0] x_r, x_f;
      logic          saw_change;

      // Each row holds its inputs n cycles; expectations apply after the last one.
      vecs[0]  = '{1'b1, 3'b111, 2, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000};
      vecs[1]  = '{1'b0, 3'b111, 5, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000};
      vecs[2]  = '{1'b0, 3'b111, 1, 3'b111, 1'b1, 1'b1, 3'b111, 3'b000};
      vecs[3]  = '{1'b0, 3'b111, 1, 3'b111, 1'b0, 1'b1, 3'b000, 3'b000};
      vecs[4]  = '{1'b0, 3'b000, 5, 3'b111, 1'b0, 1'b1, 3'b000, 3'b000};
      vecs[5]  = '{1'b0, 3'b000, 1, 3'b000, 1'b1, 1'b1, 3'b000, 3'b111};
      vecs[6]  = '{1'b0, 3'b000, 1, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000};
      vecs[7]  = '{1'b0, 3'b010, 5, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000};
      vecs[8]  = '{1'b0, 3'b010, 1, 3'b010, 1'b1, 1'b1, 3'b010, 3'b000};
      vecs[9]  = '{1'b0, 3'b010, 3, 3'b010, 1'b0, 1'b1, 3'b000, 3'b000};
      vecs[10] = '{1'b0, 3'b000, 6, 3'b000, 1'b1, 1'b1, 3'b000, 3'b010};
      vecs[11] = '{1'b0, 3'b000, 2, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000};
      vecs[12] = '{1'b0, 3'b101, 6, 3'b101, 1'b1, 1'b1, 3'b101, 3'b000};
      vecs[13] = '{1'b0, 3'b101, 1, 3'b101, 1'b0, 1'b1, 3'b000, 3'b000};

      for (int v = 0; v < 14; v++) begin
         for (int c = 0; c < vecs[v].n; c++) step(vecs[v].r, vecs[v].s);
`ifdef SWITCH_DEBOUNCER_EDGE_PULSE_EN
         x_r = vecs[v].x_rise;
         x_f = vecs[v].x_fall;
`else
         x_r = '0;
         x_f = '0;
`endif
         check($sformatf("vec%0d_stable", v),  32'(sw_stable),  32'(vecs[v].x_stable));
         check($sformatf("vec%0d_changed", v), 32'(sw_changed), 32'(vecs[v].x_changed));
         check($sformatf("vec%0d_ready", v),   32'(ready),      32'(vecs[v].x_ready));
         check($sformatf("vec%0d_rise", v),    32'(rise_pulse), 32'(x_r));
         check($sformatf("vec%0d_fall", v),    32'(fall_pulse), 32'(x_f));
      end

      // Bounce rejection on channel 0.
      for (int c = 0; c < 8; c++) step(1'b0, 3'b000);
      check("bounce_pre_stable", 32'(sw_stable), 32'h0);
      saw_change = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step(1'b0, (c % 2 == 0) ? 3'b001 : 3'b000);
         saw_change |= sw_changed;
      end
      for (int c = 0; c < 8; c++) begin
         step(1'b0, 3'b000);
         saw_change |= sw_changed;
      end
      check("bounce_no_change", 32'(saw_change), 32'h0);
      check("bounce_stable0",   32'(sw_stable[0]), 32'h0);

      // Reset mid-PENDING discards the partial count on channel 2.
      for (int c = 0; c < 3; c++) step(1'b0, 3'b100);
      step(1'b1, 3'b100);
      check("midrst_ready_low", 32'(ready), 32'h0);
      for (int c = 1; c <= 5; c++) begin
         step(1'b0, 3'b100);
         check($sformatf("midrst_hold_e%0d", c), 32'(sw_stable[2]), 32'h0);
      end
      step(1'b0, 3'b100);
      check("midrst_rise_e6",  32'(sw_stable[2]), 32'h1);
      check("midrst_ready_e6", 32'(ready), 32'h1);
      check("midrst_pulse_e6", 32'(sw_changed), 32'h1);

      // Randomised traffic with occasional resets, checked by the model.
      for (int c = 0; c < 3000; c++) begin
         logic [NC-1:0] s;
         s = sw_in;
         if ($urandom_range(0, 7) == 0) s[$urandom_range(0, NC-1)] ^= 1'b1;
         step(($urandom_range(0, 199) == 0), s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule : tb_switch_debouncer
